// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the hazard controller.
package hazard_ctrl_pkg;

  // Register $0 is hard-wired to zero and never creates a dependence.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the saturating stall-cycle counter.
  localparam int unsigned STALL_TOTAL_W = 16;

  // Number of stall cycles an ID instruction requires.
  typedef enum logic [1:0] {
    STALL_NONE = 2'd0,
    STALL_ONE  = 2'd1,
    STALL_TWO  = 2'd2
  } stall_len_e;

  // Larger of two stall lengths; used when several hazard rules fire at once.
  function automatic stall_len_e stall_max(input stall_len_e a, input stall_len_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_dep_match.sv
// Source/destination register comparator with $0 exclusion.
module dep_match
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       src_used_i,
  input  logic [4:0] dst_i,
  output logic       match_o
);

  // A dependence exists only for a used source naming a non-zero destination.
  assign match_o = src_used_i && (src_i == dst_i) && (dst_i != REG_ZERO);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / early-branch hazard controller: computes stall length, drives
// pipeline enables and keeps a saturating count of stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               ID_Rs,
  input  logic [4:0]               ID_Rt,
  input  logic                     ID_UsesRs,
  input  logic                     ID_UsesRt,
  input  logic                     ID_EarlyUse,
  input  logic                     ID_Redirect,
  input  logic                     EX_MemRead,
  input  logic                     EX_RegWrite,
  input  logic [4:0]               EX_Rd,
  input  logic                     MEM_MemRead,
  input  logic [4:0]               MEM_Rd,
  output logic                     PC_Write,
  output logic                     IFID_Write,
  output logic                     IFID_Flush,
  output logic                     IDEX_Bubble,
  output logic [1:0]               StallCnt,
  output logic [STALL_TOTAL_W-1:0] StallTotal
);

  logic                     ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic                     ex_hit, mem_hit;
  stall_len_e               need_n;
  logic                     stall;
  logic [1:0]               cnt_q, cnt_d;
  logic [STALL_TOTAL_W-1:0] total_q, total_d;

  dep_match u_ex_rs (
    .src_i      (ID_Rs),
    .src_used_i (ID_UsesRs),
    .dst_i      (EX_Rd),
    .match_o    (ex_rs_hit)
  );

  dep_match u_ex_rt (
    .src_i      (ID_Rt),
    .src_used_i (ID_UsesRt),
    .dst_i      (EX_Rd),
    .match_o    (ex_rt_hit)
  );

  dep_match u_mem_rs (
    .src_i      (ID_Rs),
    .src_used_i (ID_UsesRs),
    .dst_i      (MEM_Rd),
    .match_o    (mem_rs_hit)
  );

  dep_match u_mem_rt (
    .src_i      (ID_Rt),
    .src_used_i (ID_UsesRt),
    .dst_i      (MEM_Rd),
    .match_o    (mem_rt_hit)
  );

  assign ex_hit  = ex_rs_hit  || ex_rt_hit;
  assign mem_hit = mem_rs_hit || mem_rt_hit;

  // Required stall length; only evaluated when no stall is already in progress.
  always_comb begin
    need_n = STALL_NONE;
    if (cnt_q == '0) begin
      if (EX_MemRead && ex_hit)
        need_n = stall_max(need_n, ID_EarlyUse ? STALL_TWO : STALL_ONE);
      if (EX_RegWrite && !EX_MemRead && ex_hit && ID_EarlyUse)
        need_n = stall_max(need_n, STALL_ONE);
      if (MEM_MemRead && mem_hit && ID_EarlyUse)
        need_n = stall_max(need_n, STALL_ONE);
    end
  end

  assign stall = (cnt_q != '0) || (need_n != STALL_NONE);

  // Pipeline control; reset forces free-running values regardless of inputs.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    if (reset) begin
      if (stall) begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end else begin
        IFID_Flush  = ID_Redirect;
      end
    end
  end

  // Next-state for the remaining-stall counter and the saturating total.
  always_comb begin
    cnt_d   = '0;
    total_d = total_q;
    if (cnt_q != '0)
      cnt_d = cnt_q - 2'd1;
    else if (need_n != STALL_NONE)
      cnt_d = 2'(need_n) - 2'd1;
    if (stall && (total_q != '1))
      total_d = total_q + STALL_TOTAL_W'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      total_q <= total_d;
    end
  end

  assign StallCnt   = cnt_q;
  assign StallTotal = total_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 clk  input  1  pipeline clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 ID_Rs, ID_Rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 ID_UsesRs, ID_UsesRt  input  1 each  the ID instruction reads Rs / Rt.
REQ-006 ID_EarlyUse  input  1  the ID instruction needs its operands in ID (beq/bne/jr).
REQ-007 ID_Redirect  input  1  the ID instruction changes the PC (taken branch, j, jal, jr); valid only when no stall is requested.
REQ-008 EX_MemRead, EX_RegWrite  input  1 each; EX_Rd  input  5  destination state of the instruction in EX.
REQ-009 MEM_MemRead  input  1; MEM_Rd  input  5  destination state of the instruction in MEM.
REQ-010 PC_Write, IFID_Write  output  1 each  enables for the PC register and the IF/ID register.
REQ-011 IFID_Flush  output  1  clears IF/ID to a nop on the next edge.
REQ-012 IDEX_Bubble  output  1  loads a nop into ID/EX on the next edge.
REQ-013 StallCnt  output  2  remaining stall cycles, registered.
REQ-014 StallTotal  output  16  saturating count of stall cycles, registered.

Function
REQ-015 Dependence test: src matches dst when the source is used, the register numbers are equal, and dst is not register 0.
REQ-016 When StallCnt is 0, the required stall cycles N SHALL be computed combinationally.
- EX load feeding any source with ID_EarlyUse=1: N=2.
- EX load feeding any source with ID_EarlyUse=0: N=1.
- EX ALU write (RegWrite and not MemRead) feeding an early-use source: N=1.
- MEM load feeding an early-use source: N=1.
- Otherwise N=0; when several rules apply, the maximum N SHALL be used.
REQ-017 Stall cycle, defined as (StallCnt≠0) or (N≠0): PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
REQ-018 On a detect edge (StallCnt=0 and N≠0), StallCnt SHALL load N-1.
REQ-019 While StallCnt≠0, stall cycles SHALL continue and StallCnt SHALL decrement by 1 per edge until it reaches 0.
REQ-020 The block SHALL re-evaluate N in the cycle after StallCnt returns to 0; its pipeline inputs will have advanced by then.
REQ-021 Non-stall cycle: PC_Write=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=ID_Redirect.
REQ-022 ID_Redirect SHALL be ignored in any stall cycle, so that no flush occurs on unresolved operands.
REQ-023 StallTotal SHALL increment by 1 in every stall cycle and hold at 16'hFFFF.
REQ-024 All outputs except StallCnt and StallTotal SHALL be combinational from inputs and StallCnt, with zero-cycle latency.

Reset
REQ-025 Asserting reset SHALL immediately force StallCnt=0 and StallTotal=0.
REQ-026 While reset is low, outputs SHALL be PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, irrespective of inputs.
REQ-027 Reset asserted mid-stall SHALL abandon the remaining stall cycles.
REQ-028 After reset release, the first edge SHALL apply REQ-016 afresh.

Structure
REQ-029 A shared package SHALL hold:
- register-0 constant REG_ZERO=5'd0;
- stall-length constants STALL_NONE=0, STALL_ONE=1, STALL_TWO=2;
- StallTotal width constant 16.
REQ-030 The block SHALL contain one sub-module, dep_match, a combinational 5-bit source/destination comparator with the register-0 exclusion, instantiated once per source/destination pair.

Verification
REQ-031 EX lw to $8; ID add reading $8 (EarlyUse=0):
- one stall cycle;
- IDEX_Bubble=1 for 1 cycle;
- StallCnt stays 0;
- StallTotal=1.
REQ-032 EX lw to $9; ID beq reading $9: two stall cycles, with StallCnt 1 then 0, and StallTotal=2.
REQ-033 EX addu to $0; ID beq reading $0: no stall, PC_Write=1.
REQ-034 ID_Redirect=1 with no hazard: IFID_Flush=1 for exactly one cycle; with a simultaneous N=1 hazard, IFID_Flush=0 until the stall cycle ends.
REQ-035 Reset pulled low during the first cycle of a 2-cycle stall: StallCnt=0 immediately, outputs take their REQ-026 values, and StallTotal=0.
REQ-036 Force 70000 consecutive stall cycles: StallTotal saturates at 16'hFFFF.
